// File: rtl/decode_pkg.sv
// Shared opcode, class and immediate-format definitions for the decode stage,
// plus RV32I encoders used when expanding compressed instructions.
package decode_pkg;

  localparam logic [6:0] OP       = 7'b0110011;
  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] LOAD     = 7'b0000011;
  localparam logic [6:0] STORE    = 7'b0100011;
  localparam logic [6:0] BRANCH   = 7'b1100011;
  localparam logic [6:0] JAL      = 7'b1101111;
  localparam logic [6:0] JALR     = 7'b1100111;
  localparam logic [6:0] LUI      = 7'b0110111;
  localparam logic [6:0] AUIPC    = 7'b0010111;
  localparam logic [6:0] SYSTEM   = 7'b1110011;
  localparam logic [6:0] MISC_MEM = 7'b0001111;

  localparam int unsigned CLS_RTYPE  = 0;
  localparam int unsigned CLS_ITYPE  = 1;
  localparam int unsigned CLS_LOAD   = 2;
  localparam int unsigned CLS_STORE  = 3;
  localparam int unsigned CLS_BRANCH = 4;
  localparam int unsigned CLS_JAL    = 5;
  localparam int unsigned CLS_JALR   = 6;
  localparam int unsigned CLS_LUI    = 7;
  localparam int unsigned CLS_AUIPC  = 8;
  localparam int unsigned CLS_SYSTEM = 9;
  localparam int unsigned CLS_FENCE  = 10;
  localparam int unsigned NUM_CLASSES = 11;

  typedef logic [NUM_CLASSES-1:0] class_t;

  localparam class_t CLASS_NOP = 11'b000_0000_0010;

  typedef enum logic [2:0] {
    FMT_NONE, FMT_I, FMT_SH, FMT_S, FMT_B, FMT_U, FMT_J
  } imm_fmt_t;

  localparam logic [31:0] RESET_INSTR_DEFAULT = 32'h0000_0013;

  function automatic logic [31:0] enc_i(logic [11:0] imm, logic [4:0] rs1,
                                        logic [2:0] f3, logic [4:0] rd, logic [6:0] op);
    return {imm, rs1, f3, rd, op};
  endfunction

  function automatic logic [31:0] enc_s(logic [11:0] imm, logic [4:0] rs2,
                                        logic [4:0] rs1, logic [2:0] f3);
    return {imm[11:5], rs2, rs1, f3, imm[4:0], STORE};
  endfunction

  // Branch and jump offsets are passed without their always-zero bit 0.
  function automatic logic [31:0] enc_b(logic [12:1] imm, logic [4:0] rs2,
                                        logic [4:0] rs1, logic [2:0] f3);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], BRANCH};
  endfunction

  function automatic logic [31:0] enc_j(logic [20:1] imm, logic [4:0] rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, JAL};
  endfunction

  function automatic logic [31:0] enc_r(logic [6:0] f7, logic [4:0] rs2, logic [4:0] rs1,
                                        logic [2:0] f3, logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, OP};
  endfunction

  function automatic logic [31:0] enc_u(logic [19:0] imm, logic [4:0] rd, logic [6:0] op);
    return {imm, rd, op};
  endfunction

endpackage

// File: rtl/decode_c_expand.sv
// Combinational RV32C (quadrants 0-2, no FP) to RV32I expander.
module c_expand
  import decode_pkg::*;
(
  input  logic [15:0] instr16,
  output logic [31:0] instr32,
  output logic        c_illegal
);

  logic [15:0] c;
  logic [4:0]  rd, rs2, rdp, rs1p;
  logic [11:0] imm6;
  logic [9:0]  nzuimm;
  logic [6:0]  uimm_w;
  logic [11:1] cj;
  logic [8:1]  cb;
  logic [9:0]  sp16;
  logic [7:0]  lwsp, swsp;

  assign c      = instr16;
  assign rd     = c[11:7];
  assign rs2    = c[6:2];
  assign rdp    = {2'b01, c[4:2]};
  assign rs1p   = {2'b01, c[9:7]};
  assign imm6   = {{6{c[12]}}, c[12], c[6:2]};
  assign nzuimm = {c[10:7], c[12:11], c[5], c[6], 2'b00};
  assign uimm_w = {c[5], c[12:10], c[6], 2'b00};
  assign cj     = {c[12], c[8], c[10:9], c[6], c[7], c[2], c[11], c[5:3]};
  assign cb     = {c[12], c[6:5], c[2], c[11:10], c[4:3]};
  assign sp16   = {c[12], c[4:3], c[5], c[2], c[6], 4'b0000};
  assign lwsp   = {c[3:2], c[12], c[6:4], 2'b00};
  assign swsp   = {c[8:7], c[12:9], 2'b00};

  always_comb begin
    instr32   = '0;
    c_illegal = 1'b0;
    case ({c[1:0], c[15:13]})
      5'b00_000: if (nzuimm == '0) c_illegal = 1'b1;
                 else instr32 = enc_i({2'b00, nzuimm}, 5'd2, 3'b000, rdp, OP_IMM);
      5'b00_010: instr32 = enc_i({5'b0, uimm_w}, rs1p, 3'b010, rdp, LOAD);
      5'b00_110: instr32 = enc_s({5'b0, uimm_w}, rdp, rs1p, 3'b010);
      5'b01_000: instr32 = enc_i(imm6, rd, 3'b000, rd, OP_IMM);
      5'b01_001: instr32 = enc_j({{9{cj[11]}}, cj}, 5'd1);
      5'b01_010: instr32 = enc_i(imm6, 5'd0, 3'b000, rd, OP_IMM);
      5'b01_011: begin
        // rd=2 selects c.addi16sp; any other rd is c.lui.
        if (rd == 5'd2) begin
          if (sp16 == '0) c_illegal = 1'b1;
          else instr32 = enc_i({{2{sp16[9]}}, sp16}, 5'd2, 3'b000, 5'd2, OP_IMM);
        end else if (imm6 == '0) c_illegal = 1'b1;
        else instr32 = enc_u({imm6[11], imm6[11], imm6[11:6], imm6}, rd, LUI);
      end
      5'b01_100: begin
        case (c[11:10])
          2'b00: if (c[12]) c_illegal = 1'b1;
                 else instr32 = enc_i({7'b0, c[6:2]}, rs1p, 3'b101, rs1p, OP_IMM);
          2'b01: if (c[12]) c_illegal = 1'b1;
                 else instr32 = enc_i({7'b0100000, c[6:2]}, rs1p, 3'b101, rs1p, OP_IMM);
          2'b10: instr32 = enc_i(imm6, rs1p, 3'b111, rs1p, OP_IMM);
          default: begin
            if (c[12]) c_illegal = 1'b1;
            else begin
              case (c[6:5])
                2'b00:   instr32 = enc_r(7'b0100000, rdp, rs1p, 3'b000, rs1p);
                2'b01:   instr32 = enc_r(7'b0000000, rdp, rs1p, 3'b100, rs1p);
                2'b10:   instr32 = enc_r(7'b0000000, rdp, rs1p, 3'b110, rs1p);
                default: instr32 = enc_r(7'b0000000, rdp, rs1p, 3'b111, rs1p);
              endcase
            end
          end
        endcase
      end
      5'b01_101: instr32 = enc_j({{9{cj[11]}}, cj}, 5'd0);
      5'b01_110: instr32 = enc_b({{4{cb[8]}}, cb}, 5'd0, rs1p, 3'b000);
      5'b01_111: instr32 = enc_b({{4{cb[8]}}, cb}, 5'd0, rs1p, 3'b001);
      5'b10_000: if (c[12]) c_illegal = 1'b1;
                 else instr32 = enc_i({7'b0, c[6:2]}, rd, 3'b001, rd, OP_IMM);
      5'b10_010: if (rd == '0) c_illegal = 1'b1;
                 else instr32 = enc_i({4'b0, lwsp}, 5'd2, 3'b010, rd, LOAD);
      5'b10_100: begin
        if (!c[12]) begin
          if (rs2 != '0) instr32 = enc_r(7'b0, rs2, 5'd0, 3'b000, rd);
          else if (rd == '0) c_illegal = 1'b1;
          else instr32 = enc_i(12'd0, rd, 3'b000, 5'd0, JALR);
        end else begin
          if (rs2 != '0) instr32 = enc_r(7'b0, rs2, rd, 3'b000, rd);
          else if (rd == '0) instr32 = enc_i(12'd1, 5'd0, 3'b000, 5'd0, SYSTEM);
          else instr32 = enc_i(12'd0, rd, 3'b000, 5'd1, JALR);
        end
      end
      5'b10_110: instr32 = enc_s({4'b0, swsp}, rs2, 5'd2, 3'b010);
      default:   c_illegal = (c[1:0] != 2'b11);
    endcase
  end

endmodule

// File: rtl/decode.sv
// Instruction decode stage: compressed expansion, field/immediate extraction
// and the pipeline register feeding execute.
module decode
  import decode_pkg::*;
#(
  parameter logic [31:0] RESET_INSTR = RESET_INSTR_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] i_pc,
  input  logic [31:0] i_instr,
  input  logic        i_clk_en,
  input  logic        i_stall,
  input  logic        i_flush,
  output logic [31:0] o_pc,
  output logic [31:0] o_pc_next,
  output logic [31:0] o_instr,
  output logic [4:0]  o_rs1_addr,
  output logic [4:0]  o_rs2_addr,
  output logic [4:0]  o_rd_addr,
  output logic [31:0] o_imm,
  output logic [2:0]  o_funct3,
  output logic [6:0]  o_funct7,
  output logic [10:0] o_class,
  output logic        o_is_compressed,
  output logic        o_illegal,
  output logic        o_clk_en
);

  logic        comp, c_illegal, c_ill;
  logic [31:0] exp_instr, x, imm;
  class_t      cls;
  imm_fmt_t    fmt;

  c_expand u_c_expand (
    .instr16   (i_instr[15:0]),
    .instr32   (exp_instr),
    .c_illegal (c_illegal)
  );

  assign comp  = (i_instr[1:0] != 2'b11);
  assign c_ill = comp & c_illegal;
  assign x     = comp ? exp_instr : i_instr;

  always_comb begin
    cls = '0;
    fmt = FMT_NONE;
    case (x[6:0])
      OP:       cls[CLS_RTYPE] = 1'b1;
      OP_IMM: begin
        cls[CLS_ITYPE] = 1'b1;
        fmt = (x[14:12] == 3'b001 || x[14:12] == 3'b101) ? FMT_SH : FMT_I;
      end
      LOAD:     begin cls[CLS_LOAD]   = 1'b1; fmt = FMT_I; end
      STORE:    begin cls[CLS_STORE]  = 1'b1; fmt = FMT_S; end
      BRANCH:   begin cls[CLS_BRANCH] = 1'b1; fmt = FMT_B; end
      JAL:      begin cls[CLS_JAL]    = 1'b1; fmt = FMT_J; end
      JALR:     begin cls[CLS_JALR]   = 1'b1; fmt = FMT_I; end
      LUI:      begin cls[CLS_LUI]    = 1'b1; fmt = FMT_U; end
      AUIPC:    begin cls[CLS_AUIPC]  = 1'b1; fmt = FMT_U; end
      SYSTEM:   begin cls[CLS_SYSTEM] = 1'b1; fmt = FMT_I; end
      MISC_MEM: begin cls[CLS_FENCE]  = 1'b1; fmt = FMT_I; end
      default:  ;
    endcase
    if (c_ill) begin
      cls = '0;
      fmt = FMT_NONE;
    end
  end

  always_comb begin
    imm = '0;
    case (fmt)
      FMT_I:   imm = {{20{x[31]}}, x[31:20]};
      FMT_SH:  imm = {27'b0, x[24:20]};
      FMT_S:   imm = {{20{x[31]}}, x[31:25], x[11:7]};
      FMT_B:   imm = {{19{x[31]}}, x[31], x[7], x[30:25], x[11:8], 1'b0};
      FMT_U:   imm = {x[31:12], 12'b0};
      FMT_J:   imm = {{11{x[31]}}, x[31], x[19:12], x[20], x[30:21], 1'b0};
      default: imm = '0;
    endcase
  end

  // Flush outranks stall; both leave the data registers untouched.
  always_ff @(posedge clk) begin
    if (rst) begin
      o_pc            <= '0;
      o_pc_next       <= '0;
      o_instr         <= RESET_INSTR;
      o_rs1_addr      <= '0;
      o_rs2_addr      <= '0;
      o_rd_addr       <= '0;
      o_imm           <= '0;
      o_funct3        <= '0;
      o_funct7        <= '0;
      o_class         <= CLASS_NOP;
      o_is_compressed <= 1'b0;
      o_illegal       <= 1'b0;
      o_clk_en        <= 1'b0;
    end else if (i_flush) begin
      o_clk_en <= 1'b0;
    end else if (!i_stall) begin
      o_clk_en <= i_clk_en;
      if (i_clk_en) begin
        o_pc            <= i_pc;
        o_pc_next       <= i_pc + (comp ? 32'd2 : 32'd4);
        o_instr         <= x;
        o_rs1_addr      <= x[19:15];
        o_rs2_addr      <= x[24:20];
        o_rd_addr       <= x[11:7];
        o_imm           <= imm;
        o_funct3        <= x[14:12];
        o_funct7        <= x[31:25];
        o_class         <= cls;
        o_is_compressed <= comp;
        o_illegal       <= (cls == '0);
      end
    end
  end

endmodule

// File: tb/tb_decode.sv
// Randomized bench for decode, checked against an ISA-level reference model.
module tb_decode;

  logic        clk = 1'b0;
  logic        rst, i_clk_en, i_stall, i_flush;
  logic [31:0] i_pc, i_instr;
  logic [31:0] o_pc, o_pc_next, o_instr, o_imm;
  logic [4:0]  o_rs1_addr, o_rs2_addr, o_rd_addr;
  logic [2:0]  o_funct3;
  logic [6:0]  o_funct7;
  logic [10:0] o_class;
  logic        o_is_compressed, o_illegal, o_clk_en;

  always #5 clk = ~clk;

  decode #(.RESET_INSTR(32'h0000_0013)) dut (
    .clk(clk), .rst(rst), .i_pc(i_pc), .i_instr(i_instr), .i_clk_en(i_clk_en),
    .i_stall(i_stall), .i_flush(i_flush), .o_pc(o_pc), .o_pc_next(o_pc_next),
    .o_instr(o_instr), .o_rs1_addr(o_rs1_addr), .o_rs2_addr(o_rs2_addr),
    .o_rd_addr(o_rd_addr), .o_imm(o_imm), .o_funct3(o_funct3), .o_funct7(o_funct7),
    .o_class(o_class), .o_is_compressed(o_is_compressed), .o_illegal(o_illegal),
    .o_clk_en(o_clk_en)
  );

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  // Opcodes listed in class-bit order: rtype..fence.
  logic [6:0] opcodes [11] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F,
                               7'h67, 7'h37, 7'h17, 7'h73, 7'h0F};

  logic        m_ce, m_comp, m_ill, m_instr_ok, m_imm_ok;
  logic [31:0] m_pc, m_pcn, m_instr, m_imm;
  logic [10:0] m_cls;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
  endtask

  function automatic logic [31:0] enc_i(int f12, int rs1, int f3, int rd, int op);
    return ((f12 & 'hfff) << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | op;
  endfunction
  function automatic logic [31:0] enc_s(int imm, int rs2, int rs1, int f3);
    return (((imm >> 5) & 127) << 25) | (rs2 << 20) | (rs1 << 15) | (f3 << 12)
           | ((imm & 31) << 7) | 'h23;
  endfunction
  function automatic logic [31:0] enc_b(int imm, int rs2, int rs1, int f3);
    return (((imm >> 12) & 1) << 31) | (((imm >> 5) & 63) << 25) | (rs2 << 20) | (rs1 << 15)
           | (f3 << 12) | (((imm >> 1) & 15) << 8) | (((imm >> 11) & 1) << 7) | 'h63;
  endfunction
  function automatic logic [31:0] enc_j(int imm, int rd);
    return (((imm >> 20) & 1) << 31) | (((imm >> 1) & 1023) << 21) | (((imm >> 11) & 1) << 20)
           | (((imm >> 12) & 255) << 12) | (rd << 7) | 'h6F;
  endfunction
  function automatic logic [31:0] enc_r(int f7, int rs2, int rs1, int f3, int rd);
    return (f7 << 25) | (rs2 << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | 'h33;
  endfunction

  function automatic int bt(int c, int n);
    return (c >> n) & 1;
  endfunction

  // RV32C semantics, written out per mnemonic.
  function automatic void expand(input logic [15:0] c16, output logic ok, output logic [31:0] w);
    int c, q, f, b12, rd, rs2, rdp, rs1p, imm6, off, sub;
    c = c16; ok = 1'b1; w = '0;
    q = c & 3; f = (c >> 13) & 7; b12 = bt(c, 12);
    rd = (c >> 7) & 31; rs2 = (c >> 2) & 31;
    rdp = 8 + ((c >> 2) & 7); rs1p = 8 + ((c >> 7) & 7);
    imm6 = b12 ? rs2 - 32 : rs2;
    if (q == 0) begin
      off = bt(c, 6) * 4 + ((c >> 10) & 7) * 8 + bt(c, 5) * 64;
      if (f == 0) begin
        off = bt(c, 6) * 4 + bt(c, 5) * 8 + ((c >> 11) & 3) * 16 + ((c >> 7) & 15) * 64;
        if (off == 0) ok = 1'b0; else w = enc_i(off, 2, 0, rdp, 'h13);
      end else if (f == 2) w = enc_i(off, rs1p, 2, rdp, 'h03);
      else if (f == 6) w = enc_s(off, rdp, rs1p, 2);
      else ok = 1'b0;
    end else if (q == 1) begin
      case (f)
        0: w = enc_i(imm6, rd, 0, rd, 'h13);
        1, 5: begin
          off = (b12 ? -2048 : 0) + bt(c, 11) * 16 + ((c >> 9) & 3) * 256 + bt(c, 8) * 1024
                + bt(c, 7) * 64 + bt(c, 6) * 128 + bt(c, 2) * 32 + ((c >> 3) & 7) * 2;
          w = enc_j(off, (f == 1) ? 1 : 0);
        end
        2: w = enc_i(imm6, 0, 0, rd, 'h13);
        3: if (rd == 2) begin
             off = (b12 ? -512 : 0) + bt(c, 6) * 16 + bt(c, 5) * 64 + ((c >> 3) & 3) * 128
                   + bt(c, 2) * 32;
             if (off == 0) ok = 1'b0; else w = enc_i(off, 2, 0, 2, 'h13);
           end else if (imm6 == 0) ok = 1'b0;
           else w = ((imm6 << 12) & 'hfffff000) | (rd << 7) | 'h37;
        4: begin
          sub = (c >> 10) & 3;
          if (sub == 0) begin if (b12) ok = 1'b0; else w = enc_i(rs2, rs1p, 5, rs1p, 'h13); end
          else if (sub == 1) begin if (b12) ok = 1'b0; else w = enc_i(1024 + rs2, rs1p, 5, rs1p, 'h13); end
          else if (sub == 2) w = enc_i(imm6, rs1p, 7, rs1p, 'h13);
          else if (b12) ok = 1'b0;
          else case ((c >> 5) & 3)
            0: w = enc_r(32, rdp, rs1p, 0, rs1p);
            1: w = enc_r(0, rdp, rs1p, 4, rs1p);
            2: w = enc_r(0, rdp, rs1p, 6, rs1p);
            default: w = enc_r(0, rdp, rs1p, 7, rs1p);
          endcase
        end
        default: begin
          off = (b12 ? -256 : 0) + ((c >> 3) & 3) * 2 + ((c >> 10) & 3) * 8 + bt(c, 2) * 32
                + ((c >> 5) & 3) * 64;
          w = enc_b(off, 0, rs1p, (f == 6) ? 0 : 1);
        end
      endcase
    end else begin
      if (f == 0) begin if (b12) ok = 1'b0; else w = enc_i(rs2, rd, 1, rd, 'h13); end
      else if (f == 2) begin
        off = ((c >> 4) & 7) * 4 + b12 * 32 + ((c >> 2) & 3) * 64;
        if (rd == 0) ok = 1'b0; else w = enc_i(off, 2, 2, rd, 'h03);
      end else if (f == 4) begin
        if (!b12) begin
          if (rs2 != 0) w = enc_r(0, rs2, 0, 0, rd);
          else if (rd == 0) ok = 1'b0;
          else w = enc_i(0, rd, 0, 0, 'h67);
        end else begin
          if (rs2 != 0) w = enc_r(0, rs2, rd, 0, rd);
          else if (rd == 0) w = enc_i(1, 0, 0, 0, 'h73);
          else w = enc_i(0, rd, 0, 1, 'h67);
        end
      end else if (f == 6) w = enc_s(((c >> 9) & 15) * 4 + ((c >> 7) & 3) * 64, rs2, 2, 2);
      else ok = 1'b0;
    end
  endfunction

  function automatic void dec(input logic [31:0] w, output int idx, output logic [31:0] imm);
    int f3, t;
    idx = -1; imm = '0;
    for (int i = 0; i < 11; i++) if (opcodes[i] == w[6:0]) idx = i;
    f3 = (w >> 12) & 7;
    case (idx)
      1: if (f3 == 1 || f3 == 5) imm = (w >> 20) & 31;
         else imm = $signed(w) >>> 20;
      2, 6, 9, 10: imm = $signed(w) >>> 20;
      3: begin t = $signed(w) >>> 25; imm = (t << 5) | ((w >> 7) & 31); end
      4: imm = ((w[31]) ? 32'hFFFF_F000 : 32'h0) | (((w >> 7) & 1) << 11)
               | (((w >> 25) & 63) << 5) | (((w >> 8) & 15) << 1);
      5: imm = ((w[31]) ? 32'hFFF0_0000 : 32'h0) | (((w >> 12) & 255) << 12)
               | (((w >> 20) & 1) << 11) | (((w >> 21) & 1023) << 1);
      7, 8: imm = w & 32'hFFFF_F000;
      default: imm = '0;
    endcase
  endfunction

  task automatic model_edge;
    logic ok;
    logic [31:0] w, imm;
    int idx;
    if (rst) begin
      m_ce = 0; m_pc = 0; m_pcn = 0; m_instr = 32'h13; m_imm = 0; m_cls = 11'd2;
      m_comp = 0; m_ill = 0; m_instr_ok = 1; m_imm_ok = 1;
    end else if (i_flush) m_ce = 0;
    else if (i_stall) ;
    else if (!i_clk_en) m_ce = 0;
    else begin
      m_ce = 1; m_pc = i_pc;
      m_comp = (i_instr & 3) != 3;
      m_pcn = i_pc + (m_comp ? 2 : 4);
      if (m_comp) expand(i_instr[15:0], ok, w);
      else begin ok = 1'b1; w = i_instr; end
      dec(w, idx, imm);
      if (!ok) idx = -1;
      m_ill = (idx < 0);
      m_cls = m_ill ? 11'd0 : 11'(1 << idx);
      m_instr = w; m_instr_ok = ok; m_imm = imm; m_imm_ok = !m_ill;
    end
  endtask

  task automatic tick;
    model_edge();
    @(posedge clk);
    #1;
    check("clk_en", o_clk_en, m_ce);
    check("pc", o_pc, m_pc);
    check("pc_next", o_pc_next, m_pcn);
    check("class", o_class, m_cls);
    check("illegal", o_illegal, m_ill);
    check("compressed", o_is_compressed, m_comp);
    if (m_instr_ok) begin
      check("instr", o_instr, m_instr);
      check("rd", o_rd_addr, (m_instr >> 7) & 31);
      check("rs1", o_rs1_addr, (m_instr >> 15) & 31);
      check("rs2", o_rs2_addr, (m_instr >> 20) & 31);
      check("funct3", o_funct3, (m_instr >> 12) & 7);
      check("funct7", o_funct7, m_instr >> 25);
    end
    if (m_imm_ok) check("imm", o_imm, m_imm);
  endtask

  task automatic drive(input logic [31:0] pc, input logic [31:0] ins,
                       input logic ce, input logic st, input logic fl);
    i_pc = pc; i_instr = ins; i_clk_en = ce; i_stall = st; i_flush = fl;
    tick();
  endtask

  initial begin
    logic [31:0] r;
    int unsigned sel;
    rst = 1; i_clk_en = 1; i_stall = 0; i_flush = 0; i_pc = 32'h40; i_instr = 32'h00A0_0093;
    tick();
    tick();
    rst = 0;
    drive(32'h100, 32'h00A0_0093, 1, 0, 0);
    drive(32'h102, 32'h0000_4095, 1, 0, 0);
    drive(32'h100, 32'h00A0_0093, 1, 0, 0);
    for (int i = 0; i < 3; i++) drive(32'h104, 32'h0000_4095, 1, 1, 0);
    drive(32'h104, 32'h0000_4095, 1, 0, 0);
    drive(32'h200, 32'h00A0_0093, 1, 1, 1);
    drive(32'h204, 32'h0000_0000, 1, 0, 0);
    drive(32'h208, 32'hFFFF_FFFF, 1, 0, 0);
    drive(32'h20C, 32'h0000_8002, 1, 0, 0);
    drive(32'h20E, 32'h0000_0004, 1, 0, 0);
    drive(32'h210, 32'hFE00_0EE3, 1, 0, 0);
    drive(32'h214, 32'h1234_0000, 0, 0, 0);
    drive(32'hFFFF_FFFE, 32'hABCD_4095, 1, 0, 0);
    for (int n = 0; n < 800; n++) begin
      rst      = ($urandom_range(0, 63) == 0);
      i_flush  = ($urandom_range(0, 9) == 0);
      i_stall  = ($urandom_range(0, 4) == 0);
      i_clk_en = ($urandom_range(0, 3) != 0);
      i_pc     = $urandom & 32'hFFFF_FFFE;
      sel      = $urandom_range(0, 9);
      r        = $urandom;
      if (sel < 5) r[1:0] = 2'($urandom_range(0, 2));
      else if (sel < 9) r[6:0] = opcodes[$urandom_range(0, 10)];
      i_instr = r;
      tick();
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
